// File: rtl/adc_pkt_sched_pkg.sv
// Shared types and helpers for the ADC packet scheduler.
// Holds the FSM state encoding, slot geometry and the FIFO byte-index helper.
package adc_pkt_sched_pkg;

    localparam int NGRP   = 8;
    localparam int SLOT_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_RELS = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN,
        LOAD = ST_LOAD,
        WAIT = ST_WAIT,
        RELS = ST_RELS,
        GAP  = ST_GAP
    } state_t;

    // Top bit of group g's byte inside fifoi_grxd: 8g+7.
    function automatic logic [SLOT_W-1:0] ind_of(input logic [2:0] g);
        return {2'b00, g, 3'b111};
    endfunction

endpackage

// File: rtl/adc_pkt_slot_tbl.sv
// Eight-slot descriptor register file feeding the packetizer.
// Single-cycle write/mark/clear; no backpressure, clear has priority.
module adc_pkt_slot_tbl
    import adc_pkt_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [2:0]               slot,
    input  logic [2:0]               g,
    input  logic                     wide,
    input  logic                     set_end,
    input  logic                     clr,
    output logic [NGRP*SLOT_W-1:0]   intan_cmd,
    output logic [NGRP*SLOT_W-1:0]   intan_ind,
    output logic [NGRP-1:0]          intan_lrt,
    output logic [NGRP-1:0]          intan_end
);

    logic [NGRP*SLOT_W-1:0] cmd_q, ind_q;
    logic [NGRP-1:0]        lrt_q, end_q;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cmd_q <= '0;
            ind_q <= '0;
            lrt_q <= '0;
            end_q <= '0;
        end else begin
            if (wr) begin
                cmd_q[{slot, 3'b000} +: SLOT_W] <= 8'd1 << g;
                ind_q[{slot, 3'b000} +: SLOT_W] <= ind_of(g);
                lrt_q[slot]                     <= wide;
            end
            if (set_end) end_q[slot] <= 1'b1;
        end
    end

    assign intan_cmd = cmd_q;
    assign intan_ind = ind_q;
    assign intan_lrt = lrt_q;
    assign intan_end = end_q;

endmodule

// File: rtl/adc_pkt_sched.sv
// Round-robin packet scheduler: snapshots ready groups, fills slots 7..0, handshakes fs_fifo/fd_fifo.
// fs_fifo first high 10 cycles after the qualifying IDLE cycle; WAIT holds until fd_fifo (or watchdog with ADC_PKT_TMO_EN).
module adc_pkt_sched
    import adc_pkt_sched_pkg::*;
#(
    parameter int GAP_CYC = 16
`ifdef ADC_PKT_TMO_EN
    ,
    parameter int TMO_CYC = 4096
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sched_en,
    input  logic [NGRP-1:0]          grp_mask,
    input  logic [NGRP-1:0]          grp_rdy,
    input  logic [NGRP-1:0]          grp_wide,
    output logic                     fs_fifo,
    input  logic                     fd_fifo,
    output logic [NGRP*SLOT_W-1:0]   intan_cmd,
    output logic [NGRP*SLOT_W-1:0]   intan_ind,
    output logic [NGRP-1:0]          intan_lrt,
    output logic [NGRP-1:0]          intan_end,
    output logic                     busy,
    output logic [15:0]              pkt_cnt,
    output logic                     err
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t          state, nxt;
    logic [NGRP-1:0] snap, snap_wide;
    logic [2:0]      rr_ptr, scan_i, slot, last_g, scan_g, tbl_slot;
    logic [7:0]      gap_cnt;
    logic [15:0]     pkt_cnt_q;
    logic            tbl_wr, tbl_set_end, tbl_clr, tmo_hit;

    assign scan_g   = rr_ptr + scan_i;
    // slot has already stepped past the last written entry by LOAD
    assign tbl_slot = (state == LOAD) ? slot + 3'd1 : slot;

    always_comb begin
        nxt         = state;
        tbl_wr      = 1'b0;
        tbl_set_end = 1'b0;
        tbl_clr     = 1'b0;
        case (state)
            IDLE: if (sched_en && |(grp_rdy & grp_mask)) nxt = SCAN;
            SCAN: begin
                tbl_wr = snap[scan_g];
                if (scan_i == 3'd7) nxt = LOAD;
            end
            LOAD: begin
                tbl_set_end = 1'b1;
                nxt         = WAIT;
            end
            WAIT: if (fd_fifo || tmo_hit) nxt = RELS;
            RELS: if (!fd_fifo) begin
                nxt     = GAP;
                tbl_clr = 1'b1;
            end
            GAP:  if (gap_cnt == GAP_LAST) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            snap      <= '0;
            snap_wide <= '0;
            rr_ptr    <= '0;
            scan_i    <= '0;
            slot      <= '0;
            last_g    <= '0;
            gap_cnt   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (nxt == SCAN) begin
                    snap      <= grp_rdy & grp_mask;
                    snap_wide <= grp_wide;
                    slot      <= 3'd7;
                    scan_i    <= 3'd0;
                end
                SCAN: begin
                    scan_i <= scan_i + 3'd1;
                    if (snap[scan_g]) begin
                        slot   <= slot - 3'd1;
                        last_g <= scan_g;
                    end
                end
                WAIT: begin
                    if (fd_fifo) pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    if (fd_fifo || tmo_hit) rr_ptr <= last_g + 3'd1;
                end
                RELS: gap_cnt <= '0;
                GAP:  gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef ADC_PKT_TMO_EN
    localparam int            TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] wd_cnt;
    logic          err_q;

    // fd_fifo takes precedence over an expiry in the same cycle
    assign tmo_hit = (state == WAIT) && !fd_fifo && (wd_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= tmo_hit;
            wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    adc_pkt_slot_tbl u_slot_tbl (
        .clk       (clk),
        .rst       (rst),
        .wr        (tbl_wr),
        .slot      (tbl_slot),
        .g         (scan_g),
        .wide      (snap_wide[scan_g]),
        .set_end   (tbl_set_end),
        .clr       (tbl_clr),
        .intan_cmd (intan_cmd),
        .intan_ind (intan_ind),
        .intan_lrt (intan_lrt),
        .intan_end (intan_end)
    );

    assign fs_fifo = (state == WAIT);
    assign busy    = (state != IDLE);
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_adc_pkt_sched.sv
// Bench for adc_pkt_sched: descriptor table vectors through a scoreboard queue, plus hand-written corner sequences.
module tb_adc_pkt_sched;

    localparam int GAP = 6;

    logic        clk = 1'b0;
    logic        rst, sched_en, fd_fifo, fs_fifo, busy, err;
    logic [7:0]  grp_mask, grp_rdy, grp_wide, intan_lrt, intan_end;
    logic [63:0] intan_cmd, intan_ind;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    adc_pkt_sched #(
        .GAP_CYC(GAP)
`ifdef ADC_PKT_TMO_EN
        ,
        .TMO_CYC(32)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sched_en  (sched_en),
        .grp_mask  (grp_mask),
        .grp_rdy   (grp_rdy),
        .grp_wide  (grp_wide),
        .fs_fifo   (fs_fifo),
        .fd_fifo   (fd_fifo),
        .intan_cmd (intan_cmd),
        .intan_ind (intan_ind),
        .intan_lrt (intan_lrt),
        .intan_end (intan_end),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .err       (err)
    );

    typedef struct {
        logic [7:0]  mask, rdy, wide;
        logic [63:0] cmd, ind;
        logic [7:0]  lrt, endv;
    } vec_t;

    vec_t tbl[6];
    vec_t sbq[$];
    vec_t v;
    int   checks = 0;
    int   errors = 0;
    int   exp_pkt = 0;
    int   lat, k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns in the first SCAN cycle.
    task automatic trigger(input vec_t tv);
        grp_mask = tv.mask;
        grp_rdy  = tv.rdy;
        grp_wide = tv.wide;
        sched_en = 1'b1;
        sbq.push_back(tv);
        @(negedge clk);
        sched_en = 1'b0;
        grp_rdy  = 8'($urandom);
        grp_mask = 8'($urandom);
        grp_wide = 8'($urandom);
    endtask

    task automatic wait_fs(output int n);
        n = 1;
        while (!fs_fifo && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_desc();
        vec_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sbq.pop_front();
            chk("intan_cmd", intan_cmd, e.cmd);
            chk("intan_ind", intan_ind, e.ind);
            chk("intan_lrt", {56'd0, intan_lrt}, {56'd0, e.lrt});
            chk("intan_end", {56'd0, intan_end}, {56'd0, e.endv});
        end
    endtask

    // From a WAIT cycle: fd handshake, RELS hold, GAP length and descriptor clear.
    task automatic complete_pkt();
        repeat (2) @(negedge clk);
        chk("fs_hold", {63'd0, fs_fifo}, 64'd1);
        fd_fifo = 1'b1;
        @(negedge clk);
        exp_pkt++;
        chk("fs_drop", {63'd0, fs_fifo}, 64'd0);
        chk("pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt & 16'hFFFF));
        @(negedge clk);
        chk("rels_hold", {62'd0, busy, fs_fifo}, 64'b10);
        fd_fifo = 1'b0;
        @(negedge clk);
        chk("gap_clr", intan_cmd | intan_ind | {48'd0, intan_lrt, intan_end}, 64'd0);
        k = 1;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("gap_len", 64'(k), 64'(GAP + 1));
    endtask

    task automatic idle_check(input string name, input int cycles);
        int hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (busy || fs_fifo) hits++;
        end
        chk(name, 64'(hits), 64'd0);
    endtask

    initial begin
        tbl[0] = '{8'hFF, 8'h05, 8'h04, 64'h0104_0000_0000_0000, 64'h0717_0000_0000_0000, 8'h40, 8'h40};
        tbl[1] = '{8'hFF, 8'hFF, 8'h0F, 64'h0810_2040_8001_0204, 64'h1F27_2F37_3F07_0F17, 8'h87, 8'h01};
        tbl[2] = '{8'h3C, 8'hF0, 8'hFF, 64'h1020_0000_0000_0000, 64'h272F_0000_0000_0000, 8'hC0, 8'h40};
        tbl[3] = '{8'hFF, 8'h41, 8'h01, 64'h4001_0000_0000_0000, 64'h3707_0000_0000_0000, 8'h40, 8'h40};
        tbl[4] = '{8'hFF, 8'h01, 8'h00, 64'h0100_0000_0000_0000, 64'h0700_0000_0000_0000, 8'h00, 8'h80};
        tbl[5] = '{8'h80, 8'hFF, 8'h80, 64'h8000_0000_0000_0000, 64'h3F00_0000_0000_0000, 8'h80, 8'h80};

        rst = 1'b0; sched_en = 1'b0; fd_fifo = 1'b0;
        grp_mask = '0; grp_rdy = '0; grp_wide = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {60'd0, fs_fifo, busy, err, |pkt_cnt}, 64'd0);
        chk("rst_bus", intan_cmd | intan_ind | {48'd0, intan_lrt, intan_end}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Nothing may start: mask empty, then scheduler disabled.
        grp_rdy = 8'hFF; grp_mask = 8'h00; sched_en = 1'b1;
        idle_check("idle_mask0", 20);
        grp_mask = 8'hFF; sched_en = 1'b0;
        idle_check("idle_en0", 20);

        // rr_ptr chains through the table: 0,3,3,6,1,1 -> 0 afterwards.
        for (int n = 0; n < 6; n++) begin
            trigger(tbl[n]);
            wait_fs(lat);
            chk($sformatf("fs_latency_%0d", n), 64'(lat), 64'd10);
            check_desc();
            chk("busy_wait", {63'd0, busy}, 64'd1);
            complete_pkt();
        end
        // sched_en dropped during each packet: scheduler must stay parked.
        idle_check("idle_after_pkt", 12);

        // fd_fifo outside WAIT is ignored.
        v = '{8'hFF, 8'h0A, 8'h02, 64'h0208_0000_0000_0000, 64'h0F1F_0000_0000_0000, 8'h80, 8'h40};
        fd_fifo = 1'b1;
        @(negedge clk);
        trigger(v);
        repeat (3) @(negedge clk);
        fd_fifo = 1'b0;
        wait_fs(lat);
        chk("fs_latency_fd_early", 64'(lat), 64'd7);
        chk("pkt_cnt_fd_early", {48'd0, pkt_cnt}, 64'(exp_pkt));
        check_desc();
        complete_pkt();

        // Reset in the middle of WAIT.
        v = '{8'hFF, 8'h10, 8'h10, 64'h1000_0000_0000_0000, 64'h2700_0000_0000_0000, 8'h80, 8'h80};
        trigger(v);
        wait_fs(lat);
        check_desc();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_outs", {61'd0, fs_fifo, busy, err}, 64'd0);
        chk("wrst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
        chk("wrst_bus", intan_cmd | intan_ind | {48'd0, intan_lrt, intan_end}, 64'd0);
        rst = 1'b1;
        exp_pkt = 0;
        @(negedge clk);

        // rr_ptr restarts at 0 after reset: group 1 lands in slot 7.
        v = '{8'hFF, 8'h06, 8'h00, 64'h0204_0000_0000_0000, 64'h0F17_0000_0000_0000, 8'h00, 8'h40};
        trigger(v);
        wait_fs(lat);
        chk("fs_latency_post_rst", 64'(lat), 64'd10);
        check_desc();
        complete_pkt();

`ifdef ADC_PKT_TMO_EN
        // Watchdog abort with fd held low.
        v = '{8'hFF, 8'h01, 8'h01, 64'h0100_0000_0000_0000, 64'h0700_0000_0000_0000, 8'h80, 8'h80};
        trigger(v);
        wait_fs(lat);
        check_desc();
        k = 0;
        while (!err && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_delay", 64'(k), 64'd32);
        chk("tmo_fs", {63'd0, fs_fifo}, 64'd0);
        chk("tmo_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt));
        @(negedge clk);
        chk("tmo_pulse", {63'd0, err}, 64'd0);
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_to_idle", {63'd0, busy}, 64'd0);
`endif

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
